// File: rtl/block_sync_aligner.sv
// block_sync_aligner
//   Slices 66-bit blocks (2-bit sync header + 64-bit payload) out of the gearbox
//   buffer at the seeker's header offset. A HUNT/VERIFY/LOCKED header-lock FSM
//   decides when the offset can be trusted. Aligned blocks are emitted only while
//   LOCKED.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   gbox_buffer       194-bit gearbox buffer
//   gbox_cnt          gearbox view window index
//   buffer_dv         buffer/cnt valid this cycle (one FSM step per beat)
//   block_offset      seeker header offset, legal 0..65
//   blk_data_o        aligned 64-bit payload
//   blk_hdr_o         aligned 2-bit header
//   blk_dv_o          one-cycle valid pulse for blk_data_o/blk_hdr_o
//   blk_hdr_err_o     emitted header was not 01/10
//   locked_o          FSM is in LOCKED
//   relock_cnt_o      saturating count of LOCKED->HUNT transitions
module block_sync_aligner #(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_ERR = 16,
    parameter int unsigned MON_WIN    = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic         buffer_dv,
    input  logic [6:0]   block_offset,
    output logic [63:0]  blk_data_o,
    output logic [1:0]   blk_hdr_o,
    output logic         blk_dv_o,
    output logic         blk_hdr_err_o,
    output logic         locked_o,
    output logic [15:0]  relock_cnt_o
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned EW = $clog2(UNLOCK_ERR + 1);
    localparam int unsigned WW = $clog2(MON_WIN + 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e          r_state, r_state_d;
    logic [GW-1:0]   r_good, r_good_d;
    logic [EW-1:0]   r_err, r_err_d;
    logic [WW-1:0]   r_win, r_win_d;
    logic [6:0]      r_off, r_off_d;
    logic [15:0]     r_relock, r_relock_d;
    logic [63:0]     r_blk_data, r_blk_data_d;
    logic [1:0]      r_blk_hdr, r_blk_hdr_d;
    logic            r_blk_dv, r_blk_dv_d;
    logic            r_hdr_err, r_hdr_err_d;

    logic [6:0]      w_off_sel;
    logic [6:0]      w_off_cl;
    logic [7:0]      w_hdr_hi;
    logic [7:0]      w_pay_hi;
    logic [1:0]      w_hdr;
    logic [63:0]     w_pay;
    logic            w_valid;
    logic            w_wrap;
    logic            w_good_last;
    logic            w_err_last;

    // ------------------------------------------------------------------
    // Extraction. Offsets above 65 are clamped so the part-select stays
    // inside the buffer (max hi = 128 + 65 = 193), then forced invalid.
    // ------------------------------------------------------------------
    always_comb begin
        w_off_sel = (r_state == StHunt) ? block_offset : r_off;
        w_off_cl  = (w_off_sel > 7'd65) ? 7'd65 : w_off_sel;
        w_hdr_hi  = 8'd128 - {2'b00, gbox_cnt} + {1'b0, w_off_cl};
        w_pay_hi  = w_hdr_hi - 8'd2;
        w_hdr     = gbox_buffer[w_hdr_hi -: 2];
        w_pay     = gbox_buffer[w_pay_hi -: 64];
        w_valid   = (w_off_sel <= 7'd65) && ((w_hdr == 2'b01) || (w_hdr == 2'b10));
    end

    assign w_wrap      = (r_win == WW'(MON_WIN - 1));
    assign w_good_last = ((r_good + GW'(1)) == GW'(LOCK_CNT));
    assign w_err_last  = ((r_err + EW'(1)) == EW'(UNLOCK_ERR));

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d    = r_state;
        r_good_d     = r_good;
        r_err_d      = r_err;
        r_win_d      = r_win;
        r_off_d      = r_off;
        r_relock_d   = r_relock;
        r_blk_data_d = r_blk_data;
        r_blk_hdr_d  = r_blk_hdr;
        r_blk_dv_d   = 1'b0;
        r_hdr_err_d  = r_hdr_err;

        if (buffer_dv) begin
            unique case (r_state)
                StHunt: begin
                    if (w_valid) begin
                        r_off_d   = block_offset;
                        r_good_d  = GW'(1);
                        r_state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (w_valid) begin
                        r_good_d = r_good + GW'(1);
                        if (w_good_last) begin
                            r_state_d = StLocked;
                            r_err_d   = '0;
                            r_win_d   = '0;
                        end
                    end else begin
                        r_good_d  = '0;
                        r_state_d = StHunt;
                    end
                end
                StLocked: begin
                    r_blk_dv_d   = 1'b1;
                    r_blk_data_d = w_pay;
                    r_blk_hdr_d  = w_hdr;
                    r_hdr_err_d  = ~w_valid;
                    r_win_d      = w_wrap ? '0 : r_win + WW'(1);
                    // Threshold check wins over the window clear on the wrap beat.
                    if (!w_valid && w_err_last) begin
                        r_state_d = StHunt;
                        r_good_d  = '0;
                        r_err_d   = '0;
                        r_win_d   = '0;
                        if (r_relock != 16'hFFFF) begin
                            r_relock_d = r_relock + 16'd1;
                        end
                    end else if (w_wrap) begin
                        r_err_d = '0;
                    end else if (!w_valid) begin
                        r_err_d = r_err + EW'(1);
                    end
                end
                default: begin
                    r_state_d = StHunt;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= StHunt;
            r_good     <= '0;
            r_err      <= '0;
            r_win      <= '0;
            r_off      <= '0;
            r_relock   <= '0;
            r_blk_data <= '0;
            r_blk_hdr  <= '0;
            r_blk_dv   <= 1'b0;
            r_hdr_err  <= 1'b0;
        end else begin
            r_state    <= r_state_d;
            r_good     <= r_good_d;
            r_err      <= r_err_d;
            r_win      <= r_win_d;
            r_off      <= r_off_d;
            r_relock   <= r_relock_d;
            r_blk_data <= r_blk_data_d;
            r_blk_hdr  <= r_blk_hdr_d;
            r_blk_dv   <= r_blk_dv_d;
            r_hdr_err  <= r_hdr_err_d;
        end
    end

    assign blk_data_o    = r_blk_data;
    assign blk_hdr_o     = r_blk_hdr;
    assign blk_dv_o      = r_blk_dv;
    assign blk_hdr_err_o = r_hdr_err;
    assign locked_o      = (r_state == StLocked);
    assign relock_cnt_o  = r_relock;

endmodule

// File: tb/tb_block_sync_aligner.sv
// tb_block_sync_aligner
//   Directed bench for block_sync_aligner: reset/idle, lock acquisition, VERIFY
//   abort, unlock threshold, window clear (incl. bad header on the wrap beat),
//   offset jumps while locked, out-of-range offset in HUNT, mid-block reset.
module tb_block_sync_aligner;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [193:0] gbox_buffer = '0;
    logic [5:0]   gbox_cnt = '0;
    logic         buffer_dv = 1'b0;
    logic [6:0]   block_offset = '0;
    logic [63:0]  blk_data_o;
    logic [1:0]   blk_hdr_o;
    logic         blk_dv_o;
    logic         blk_hdr_err_o;
    logic         locked_o;
    logic [15:0]  relock_cnt_o;

    int total = 0;
    int bad   = 0;
    int beat_n = 0;

    block_sync_aligner dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .gbox_buffer  (gbox_buffer),
        .gbox_cnt     (gbox_cnt),
        .buffer_dv    (buffer_dv),
        .block_offset (block_offset),
        .blk_data_o   (blk_data_o),
        .blk_hdr_o    (blk_hdr_o),
        .blk_dv_o     (blk_dv_o),
        .blk_hdr_err_o(blk_hdr_err_o),
        .locked_o     (locked_o),
        .relock_cnt_o (relock_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One buffer_dv beat. The 66-bit block sits with its payload LSB at bit
    // 63 - cnt + off_data; everything else is junk. Returns with the outputs
    // produced by this beat visible.
    task automatic beat(input logic [1:0] hdr, input logic [63:0] pay,
                        input int off_data, input logic [6:0] off_port);
        logic [193:0] blk;
        logic [193:0] mask;
        logic [193:0] junk;
        int sh;
        logic [5:0] cnt;
        cnt  = 6'(beat_n % 64);
        sh   = 63 - int'(cnt) + off_data;
        blk  = {128'd0, hdr, pay};
        mask = {128'd0, 66'h3_FFFF_FFFF_FFFF_FFFF};
        junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk_i);
        gbox_cnt     = cnt;
        block_offset = off_port;
        gbox_buffer  = (junk & ~(mask << sh)) | (blk << sh);
        buffer_dv    = 1'b1;
        @(negedge clk_i);
        buffer_dv = 1'b0;
        beat_n++;
    endtask

    function automatic logic [1:0] good_hdr(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [63:0] pay_of(input int i);
        return 64'hC0DE_5A00_0000_0000 ^ (64'(i) * 64'h0001_0003_0107_0F1F);
    endfunction

    // n good beats at offset 17; checks no block is emitted and locked_o
    // rises exactly after beat 32 of a fresh lock.
    task automatic good_run(input int n, input logic exp_lock_at_end, input string tag);
        for (int i = 0; i < n; i++) begin
            beat(good_hdr(i), pay_of(i), 17, 7'd17);
            if (blk_dv_o !== 1'b0) check({tag, "_nodv"}, 64'(blk_dv_o), 64'd0);
        end
        total++;
        check({tag, "_lock"}, 64'(locked_o), 64'(exp_lock_at_end));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        beat_n = 0;
    endtask

    initial begin
        // Reset then idle
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("rst_dv", 64'(blk_dv_o), 64'd0);
        check("rst_data", blk_data_o, 64'd0);
        check("rst_hdr", 64'(blk_hdr_o), 64'd0);
        check("rst_herr", 64'(blk_hdr_err_o), 64'd0);
        check("rst_lock", 64'(locked_o), 64'd0);
        check("rst_relock", 64'(relock_cnt_o), 64'd0);

        // Clean lock: 31 beats not yet locked, 32nd locks
        good_run(31, 1'b0, "pre_lock");
        good_run(1, 1'b1, "lock32");
        beat(2'b10, 64'h0123_4567_89AB_CDEF, 17, 7'd17);
        check("first_dv", 64'(blk_dv_o), 64'd1);
        check("first_data", blk_data_o, 64'h0123_4567_89AB_CDEF);
        check("first_hdr", 64'(blk_hdr_o), 64'd2);
        check("first_herr", 64'(blk_hdr_err_o), 64'd0);
        @(negedge clk_i);
        check("dv_pulse", 64'(blk_dv_o), 64'd0);
        check("hold_data", blk_data_o, 64'h0123_4567_89AB_CDEF);

        // Offset jump while locked is ignored
        beat(2'b01, 64'hFEED_FACE_0000_1111, 17, 7'd40);
        check("jump_data", blk_data_o, 64'hFEED_FACE_0000_1111);
        check("jump_herr", 64'(blk_hdr_err_o), 64'd0);
        check("jump_lock", 64'(locked_o), 64'd1);

        // Unlock threshold: 16 consecutive bad headers (window index 2..17)
        for (int i = 0; i < 15; i++) begin
            beat(2'b00, pay_of(100 + i), 17, 7'd17);
        end
        check("bad15_lock", 64'(locked_o), 64'd1);
        check("bad15_herr", 64'(blk_hdr_err_o), 64'd1);
        beat(2'b11, 64'hDEAD_BEEF_0BAD_F00D, 17, 7'd17);
        check("unlock_lock", 64'(locked_o), 64'd0);
        check("unlock_relock", 64'(relock_cnt_o), 64'd1);
        check("unlock_dv", 64'(blk_dv_o), 64'd1);
        check("unlock_herr", 64'(blk_hdr_err_o), 64'd1);
        check("unlock_hdr", 64'(blk_hdr_o), 64'd3);
        check("unlock_data", blk_data_o, 64'hDEAD_BEEF_0BAD_F00D);

        // HUNT: out-of-range offset 70, data has a valid header at the clamp
        // position. Must not enter VERIFY, so a fresh lock takes exactly 32.
        beat(2'b01, 64'h7070_7070_7070_7070, 65, 7'd70);
        check("off70_dv", 64'(blk_dv_o), 64'd0);
        good_run(31, 1'b0, "off70_pre");
        good_run(1, 1'b1, "off70_lock");

        // VERIFY abort: unlock first, then 10 good + one 00
        for (int i = 0; i < 16; i++) beat(2'b00, pay_of(i), 17, 7'd17);
        check("relock2", 64'(relock_cnt_o), 64'd2);
        good_run(10, 1'b0, "abort_good");
        beat(2'b00, pay_of(0), 17, 7'd17);
        check("abort_dv", 64'(blk_dv_o), 64'd0);
        check("abort_lock", 64'(locked_o), 64'd0);
        // good_cnt restarted: 31 more is still short of lock
        good_run(31, 1'b0, "abort_restart");
        good_run(1, 1'b1, "abort_relock");

        // Mid-block reset clears pending blk_dv_o and lock immediately
        beat(2'b01, pay_of(7), 17, 7'd17);
        check("pre_rst_dv", 64'(blk_dv_o), 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("async_dv", 64'(blk_dv_o), 64'd0);
        check("async_lock", 64'(locked_o), 64'd0);
        check("async_relock", 64'(relock_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        beat_n = 0;

        // Window clear: 15 bad on window-1 indices 49..63 (incl. wrap beat),
        // 15 bad on window-2 indices 0..14 -> stays locked. One more -> unlock.
        good_run(32, 1'b1, "win_lock");
        for (int w = 0; w < 64; w++) begin
            beat((w >= 49) ? 2'b00 : good_hdr(w), pay_of(w), 17, 7'd17);
        end
        check("win1_lock", 64'(locked_o), 64'd1);
        for (int w = 0; w < 15; w++) beat(2'b00, pay_of(w), 17, 7'd17);
        check("win2_lock", 64'(locked_o), 64'd1);
        check("win2_relock", 64'(relock_cnt_o), 64'd0);
        beat(2'b00, pay_of(99), 17, 7'd17);
        check("win2_unlock", 64'(locked_o), 64'd0);
        check("win2_relock1", 64'(relock_cnt_o), 64'd1);

        // Idle: no beats means no state change and no dv
        repeat (5) @(negedge clk_i);
        check("idle_dv", 64'(blk_dv_o), 64'd0);
        check("idle_relock", 64'(relock_cnt_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_sync_aligner.md
Name: block_sync_aligner

Overview:
- Sits directly downstream of the 66b header seeker, on the same gearbox outputs.
- Uses the seeker's block_offset to slice 66-bit blocks (2-bit header + 64-bit payload) out of the 194-bit gearbox buffer.
- Runs a header-lock state machine and emits aligned blocks only when locked.
- Feeds the descrambler/decoder; reports lock status and relock count to status registers.

Parameters:
- LOCK_CNT, 32, consecutive valid headers required in VERIFY to reach LOCKED.
- UNLOCK_ERR, 16, bad headers within one monitor window that force LOCKED -> HUNT.
- MON_WIN, 64, monitor window length in buffer_dv beats while LOCKED.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- gbox_buffer  in  194  gearbox buffer.
- gbox_cnt  in  6  gearbox view window index.
- buffer_dv  in  1  gbox_buffer/gbox_cnt valid this cycle.
- block_offset  in  7  seeker header offset (legal 0..65).
- blk_data_o  out  64  aligned payload.
- blk_hdr_o  out  2  aligned header.
- blk_dv_o  out  1  blk_data_o/blk_hdr_o valid (1-cycle pulse).
- blk_hdr_err_o  out  1  header of emitted block is not 01/10.
- locked_o  out  1  state == LOCKED.
- relock_cnt_o  out  16  saturating count of LOCKED->HUNT transitions.

Behaviour:
- Reset (asynchronous, rst_i high):
  - state = HUNT; all counters and latched offset = 0.
  - All outputs = 0.
- Extraction (combinational, evaluated on buffer_dv cycles), with offset o:
  - header = gbox_buffer[128-gbox_cnt+o -: 2]
  - payload = gbox_buffer[126-gbox_cnt+o -: 64]
  - Header valid iff o <= 65 and header is 2'b01 or 2'b10.
  - o >= 66 counts as an invalid header; index arithmetic must not go out of range (clamp the slice to o = 65, then flag invalid).
- Offset selection:
  - HUNT uses live block_offset.
  - VERIFY and LOCKED use off_q, latched on HUNT -> VERIFY. Offset changes from the seeker are ignored until HUNT.
- Beat rule: when buffer_dv = 0, no state, counter or offset update occurs and blk_dv_o = 0.
- FSM (one step per buffer_dv beat):
  - HUNT:
    - Valid header at live offset: off_q <= block_offset; good_cnt <= 1; go to VERIFY.
    - Otherwise stay in HUNT.
  - VERIFY:
    - Valid header: good_cnt++. When good_cnt+1 == LOCK_CNT, go to LOCKED and clear err_cnt and win_cnt.
    - Invalid header: good_cnt <= 0; go to HUNT.
  - LOCKED:
    - win_cnt increments each beat and wraps at MON_WIN-1.
    - Invalid header: err_cnt++.
    - If err_cnt+1 == UNLOCK_ERR: go to HUNT, relock_cnt_o++ (saturates at 16'hFFFF), clear all counters.
    - Else on wrap: err_cnt <= 0. If a bad header lands on the wrap beat, the threshold check is made first, then err_cnt restarts at 0 (that error is not carried over).
- Output:
  - On a LOCKED beat (state before update), register payload/header at off_q.
  - blk_dv_o = 1 one cycle after that buffer_dv; blk_hdr_err_o = invalid flag.
  - The beat that causes LOCKED -> HUNT still emits its block, with blk_hdr_err_o = 1.
  - The beat that enters LOCKED emits nothing.
- Latency: buffer_dv -> blk_dv_o is exactly 1 cycle.
- locked_o is registered and follows the state with 0 extra delay, i.e. it is high in the cycle after the transition beat.
- Outputs other than blk_dv_o hold their last values when idle.
- Reset asserted mid-block returns to HUNT immediately; any pending blk_dv_o is cleared.

Test Plan:
- Reset then idle: rst_i pulse, buffer_dv = 0 for 10 cycles -> every output 0, locked_o = 0.
- Clean lock: stream with valid headers at offset 17, gbox_cnt sweeping 0..63, 33 beats -> locked_o rises after beat 32; first blk_dv_o on beat 33 carries the expected payload, blk_hdr_err_o = 0.
- VERIFY abort: 10 good headers then one 2'b00 -> back to HUNT, locked_o never set, no blk_dv_o.
- Unlock threshold: locked, inject 16 bad headers within 64 beats -> LOCKED -> HUNT on the 16th; relock_cnt_o = 1; that 16th block is emitted with blk_hdr_err_o = 1.
- Window clear: locked, 15 bad headers in window 1, 15 in window 2 -> stays locked, relock_cnt_o = 0.
- Offset change / out of range: while locked, block_offset jumps 17 -> 40 -> ignored and output unchanged. In HUNT, block_offset = 70 -> no VERIFY entry.
